// File: rtl/y_signature_collector_if.sv
// Bus bundle between the upstream stimulus/DUT side and the signature collector.
interface y_signature_collector_if #(
  parameter int Y_WIDTH   = 550,
  parameter int SIG_WIDTH = 32,
  parameter int CNT_WIDTH = 16
);
  logic                 start;
  logic [CNT_WIDTH-1:0] num_samples;
  logic [SIG_WIDTH-1:0] golden;
  logic                 y_valid;
  logic [Y_WIDTH-1:0]   y;
  logic                 busy;
  logic                 done;
  logic                 match;
  logic [SIG_WIDTH-1:0] signature;
  logic [CNT_WIDTH-1:0] sample_count;

  modport master (
    output start, num_samples, golden, y_valid, y,
    input  busy, done, match, signature, sample_count
  );

  modport slave (
    input  start, num_samples, golden, y_valid, y,
    output busy, done, match, signature, sample_count
  );
endinterface

// File: rtl/y_signature_collector.sv
// Compacts qualified samples of the y bus into a MISR signature and compares
// the final value against a golden signature latched at start.
module y_signature_collector #(
  parameter int          Y_WIDTH   = 550,
  parameter int          SIG_WIDTH = 32,
  parameter logic [31:0] POLY      = 32'h04C11DB7,
  parameter logic [31:0] SEED      = 32'hFFFFFFFF,
  parameter int          SKIP      = 1,
  parameter int          CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  y_signature_collector_if.slave   bus
);

  localparam int NSLICE    = (Y_WIDTH + SIG_WIDTH - 1) / SIG_WIDTH;
  localparam int EXT_WIDTH = NSLICE * SIG_WIDTH;
  localparam logic [SIG_WIDTH-1:0] POLY_L = SIG_WIDTH'(POLY);
  localparam logic [SIG_WIDTH-1:0] SEED_L = SIG_WIDTH'(SEED);
  // Skip counter only needs to reach SKIP-1; keep at least one bit so SKIP=0 still elaborates.
  localparam int SKW = (SKIP > 1) ? $clog2(SKIP) : 1;
  localparam logic [SKW-1:0] SKIP_LAST = SKW'((SKIP > 0) ? SKIP - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_SKIP, S_COLLECT, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [SIG_WIDTH-1:0] sig_q, sig_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] num_q, num_d;
  logic [SIG_WIDTH-1:0] golden_q, golden_d;
  logic [SKW-1:0]       skip_q, skip_d;
  logic                 match_q, match_d;

  logic [EXT_WIDTH-1:0] y_ext;
  logic [SIG_WIDTH-1:0] fold;
  logic [SIG_WIDTH-1:0] misr_next;

  // Zero-extend y to a whole number of signature-wide slices.
  assign y_ext = EXT_WIDTH'(bus.y);

  // XOR all slices of the extended bus together.
  always_comb begin
    fold = '0;
    for (int i = 0; i < NSLICE; i++) begin
      fold = fold ^ y_ext[i*SIG_WIDTH +: SIG_WIDTH];
    end
  end

  assign misr_next = {sig_q[SIG_WIDTH-2:0], 1'b0}
                   ^ (sig_q[SIG_WIDTH-1] ? POLY_L : '0)
                   ^ fold;

  // Next-state logic: start always wins and re-arms the run from scratch.
  always_comb begin
    state_d  = state_q;
    sig_d    = sig_q;
    cnt_d    = cnt_q;
    num_d    = num_q;
    golden_d = golden_q;
    skip_d   = skip_q;
    match_d  = match_q;
    if (bus.start) begin
      num_d    = bus.num_samples;
      golden_d = bus.golden;
      sig_d    = SEED_L;
      cnt_d    = '0;
      skip_d   = '0;
      match_d  = 1'b0;
      if (bus.num_samples == '0) begin
        // Zero-length run: the signature is just the seed.
        state_d = S_DONE;
        match_d = (SEED_L == bus.golden);
      end else if (SKIP > 0) begin
        state_d = S_SKIP;
      end else begin
        state_d = S_COLLECT;
      end
    end else begin
      case (state_q)
        S_SKIP: begin
          if (bus.y_valid) begin
            skip_d = skip_q + 1'b1;
            if (skip_q == SKIP_LAST) state_d = S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (bus.y_valid) begin
            sig_d = misr_next;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == num_q - 1'b1) begin
              // Compare against the value being registered this edge so match
              // is valid in the same cycle done first shows.
              state_d = S_DONE;
              match_d = (misr_next == golden_q);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sig_q    <= SEED_L;
      cnt_q    <= '0;
      num_q    <= '0;
      golden_q <= '0;
      skip_q   <= '0;
      match_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sig_q    <= sig_d;
      cnt_q    <= cnt_d;
      num_q    <= num_d;
      golden_q <= golden_d;
      skip_q   <= skip_d;
      match_q  <= match_d;
    end
  end

  assign bus.busy         = (state_q == S_SKIP) || (state_q == S_COLLECT);
  assign bus.done         = (state_q == S_DONE);
  assign bus.match        = match_q;
  assign bus.signature    = sig_q;
  assign bus.sample_count = cnt_q;

endmodule

// File: tb/tb_y_signature_collector.sv
// Randomized bench for y_signature_collector with a queue-based reference model.
// Instance dut uses SKIP=1, instance dut0 uses SKIP=0.
module tb_y_signature_collector;
  localparam int YW = 550;
  localparam int SW = 32;
  localparam int CW = 16;
  localparam logic [31:0] SEED_V = 32'hFFFFFFFF;
  localparam logic [31:0] POLY_V = 32'h04C11DB7;

  typedef logic [YW-1:0] yv_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  y_signature_collector_if #(.Y_WIDTH(YW), .SIG_WIDTH(SW), .CNT_WIDTH(CW)) bus ();
  y_signature_collector_if #(.Y_WIDTH(YW), .SIG_WIDTH(SW), .CNT_WIDTH(CW)) bus0 ();

  y_signature_collector #(.SKIP(1)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  y_signature_collector #(.SKIP(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  int n_checks = 0;
  int n_pass   = 0;

  function automatic yv_t rand_y();
    logic [575:0] t;
    for (int i = 0; i < 18; i++) t[i*32 +: 32] = $urandom();
    return t[YW-1:0];
  endfunction

  // Bit b of y lands in signature bit (b mod 32).
  function automatic logic [31:0] model_fold(input yv_t v);
    logic [31:0] f;
    f = '0;
    for (int b = 0; b < YW; b++) f[b % 32] = f[b % 32] ^ v[b];
    return f;
  endfunction

  // Signature = seed multiplied by x once per sample modulo POLY, plus each fold.
  function automatic logic [31:0] model_sig(input yv_t q[$]);
    logic [31:0] s;
    logic        carry;
    s = SEED_V;
    foreach (q[i]) begin
      carry = s[31];
      s = (s << 1) ^ (carry ? POLY_V : 32'h0) ^ model_fold(q[i]);
    end
    return s;
  endfunction

  function automatic logic o_busy(input bit w);  return w ? bus0.busy  : bus.busy;  endfunction
  function automatic logic o_done(input bit w);  return w ? bus0.done  : bus.done;  endfunction
  function automatic logic o_match(input bit w); return w ? bus0.match : bus.match; endfunction
  function automatic logic [31:0] o_sig(input bit w); return w ? bus0.signature : bus.signature; endfunction
  function automatic logic [15:0] o_cnt(input bit w); return w ? bus0.sample_count : bus.sample_count; endfunction

  task automatic drive(input bit w, input logic st, input logic [15:0] num,
                       input logic [31:0] gold, input logic v, input yv_t yy);
    if (w) begin
      bus0.start = st; bus0.num_samples = num; bus0.golden = gold; bus0.y_valid = v; bus0.y = yy;
    end else begin
      bus.start = st; bus.num_samples = num; bus.golden = gold; bus.y_valid = v; bus.y = yy;
    end
  endtask

  task automatic do_start(input bit w, input logic [15:0] num, input logic [31:0] gold);
    drive(w, 1'b1, num, gold, 1'b0, '0);
    @(negedge clk);
    drive(w, 1'b0, '0, '0, 1'b0, '0);
  endtask

  // Presents skip_n discarded samples then ys; mode 0 = no gaps, 1 = alternate, 2 = random.
  task automatic feed(input bit w, input int skip_n, input yv_t ys[$], input int mode,
                      output bit early, output bit blow, output bit tmo);
    int   total;
    int   sent;
    int   cyc;
    logic v;
    yv_t  yy;
    total = skip_n + ys.size();
    sent = 0; cyc = 0; early = 1'b0; blow = 1'b0;
    while (sent < total && cyc < 2000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 1) == 1);
      endcase
      yy = (sent < skip_n) ? rand_y() : ys[sent - skip_n];
      drive(w, 1'b0, '0, '0, v, yy);
      @(negedge clk);
      cyc++;
      if (v) sent++;
      if (sent < total && o_done(w)) early = 1'b1;
      if (sent < total && !o_busy(w)) blow = 1'b1;
    end
    drive(w, 1'b0, '0, '0, 1'b0, '0);
    tmo = (sent < total);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 1'b1, 16'd5, 32'h0, 1'b1, rand_y());
    drive(1, 1'b1, 16'd5, 32'h0, 1'b1, rand_y());
    repeat (2) @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else n_pass++;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else n_pass++;
    n_checks++; if (bus.match !== 1'b0) $display("FAIL reset_match got %b want 0", bus.match); else n_pass++;
    n_checks++; if (bus.signature !== SEED_V) $display("FAIL reset_sig got %h want %h", bus.signature, SEED_V); else n_pass++;
    n_checks++; if (bus.sample_count !== 16'd0) $display("FAIL reset_cnt got %0d want 0", bus.sample_count); else n_pass++;
    n_checks++; if (bus0.signature !== SEED_V) $display("FAIL reset_sig0 got %h want %h", bus0.signature, SEED_V); else n_pass++;
    rst_n = 1'b1;
    drive(0, 1'b0, '0, '0, 1'b0, '0);
    drive(1, 1'b0, '0, '0, 1'b0, '0);
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_start_ignored got busy=%b want 0", bus.busy); else n_pass++;
    $display("reset: sig=%h cnt=%0d", bus.signature, bus.sample_count);
  endtask

  task automatic test_all_zero();
    do_start(0, 16'd1, 32'hFB3EE249);
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL zero_busy_after_start got %b want 1", bus.busy); else n_pass++;
    drive(0, 1'b0, '0, '0, 1'b1, '0);
    @(negedge clk);
    n_checks++; if (bus.signature !== SEED_V) $display("FAIL zero_skipped_sig got %h want %h", bus.signature, SEED_V); else n_pass++;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL zero_done_early got %b want 0", bus.done); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.signature !== 32'hFB3EE249) $display("FAIL zero_sig got %h want fb3ee249", bus.signature); else n_pass++;
    n_checks++; if (bus.done !== 1'b1) $display("FAIL zero_done got %b want 1", bus.done); else n_pass++;
    n_checks++; if (bus.sample_count !== 16'd1) $display("FAIL zero_cnt got %0d want 1", bus.sample_count); else n_pass++;
    n_checks++; if (bus.match !== 1'b1) $display("FAIL zero_match got %b want 1", bus.match); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL zero_busy_done got %b want 0", bus.busy); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.signature !== 32'hFB3EE249) $display("FAIL zero_frozen got %h want fb3ee249", bus.signature); else n_pass++;
    drive(0, 1'b0, '0, '0, 1'b0, '0);
    $display("all_zero: sig=%h match=%b", bus.signature, bus.match);
  endtask

  task automatic test_fold();
    yv_t ys[$];
    yv_t yy;
    logic [31:0] exp;
    bit early, blow, tmo;
    yy = '0;
    yy[549] = 1'b1;
    do_start(1, 16'd1, 32'h0);
    drive(1, 1'b0, '0, '0, 1'b1, yy);
    @(negedge clk);
    drive(1, 1'b0, '0, '0, 1'b0, '0);
    n_checks++; if (bus0.signature !== 32'hFB3EE269) $display("FAIL fold_sig got %h want fb3ee269", bus0.signature); else n_pass++;
    n_checks++; if (bus0.done !== 1'b1) $display("FAIL fold_done got %b want 1", bus0.done); else n_pass++;
    n_checks++; if (bus0.match !== 1'b0) $display("FAIL fold_match got %b want 0", bus0.match); else n_pass++;
    $display("fold: sig=%h", bus0.signature);
    for (int i = 0; i < 4; i++) ys.push_back(rand_y());
    exp = model_sig(ys);
    do_start(1, 16'd4, exp);
    feed(1, 0, ys, 2, early, blow, tmo);
    n_checks++; if (tmo || early) $display("FAIL noskip_timing got tmo=%b early=%b want 0 0", tmo, early); else n_pass++;
    n_checks++; if (bus0.signature !== exp) $display("FAIL noskip_sig got %h want %h", bus0.signature, exp); else n_pass++;
    n_checks++; if (bus0.match !== 1'b1) $display("FAIL noskip_match got %b want 1", bus0.match); else n_pass++;
    $display("noskip run: sig=%h", bus0.signature);
  endtask

  task automatic test_gaps();
    yv_t ys[$];
    logic [31:0] exp;
    bit early, blow, tmo;
    for (int i = 0; i < 21; i++) ys.push_back(rand_y());
    exp = model_sig(ys);
    for (int mode = 0; mode < 2; mode++) begin
      do_start(0, 16'd21, (mode == 0) ? exp : (exp ^ 32'h1));
      feed(0, 1, ys, mode, early, blow, tmo);
      n_checks++; if (tmo) $display("FAIL gaps_timeout mode=%0d got timeout want none", mode); else n_pass++;
      n_checks++; if (early) $display("FAIL gaps_early_done mode=%0d got done before last valid want none", mode); else n_pass++;
      n_checks++; if (blow) $display("FAIL gaps_busy mode=%0d got busy low mid-run want high", mode); else n_pass++;
      n_checks++; if (bus.done !== 1'b1) $display("FAIL gaps_done mode=%0d got %b want 1", mode, bus.done); else n_pass++;
      n_checks++; if (bus.signature !== exp) $display("FAIL gaps_sig mode=%0d got %h want %h", mode, bus.signature, exp); else n_pass++;
      n_checks++; if (bus.sample_count !== 16'd21) $display("FAIL gaps_cnt mode=%0d got %0d want 21", mode, bus.sample_count); else n_pass++;
      n_checks++; if (bus.match !== (mode == 0)) $display("FAIL gaps_match mode=%0d got %b want %b", mode, bus.match, mode == 0); else n_pass++;
      $display("gaps mode=%0d: sig=%h match=%b", mode, bus.signature, bus.match);
    end
  endtask

  task automatic test_restart();
    yv_t ys1[$];
    yv_t ys2[$];
    logic [31:0] exp1, exp2;
    bit early, blow, tmo;
    for (int i = 0; i < 5; i++) ys1.push_back(rand_y());
    for (int i = 0; i < 3; i++) ys2.push_back(rand_y());
    exp1 = model_sig(ys1);
    exp2 = model_sig(ys2);
    do_start(0, 16'd10, 32'h0);
    feed(0, 1, ys1, 2, early, blow, tmo);
    n_checks++; if (bus.sample_count !== 16'd5) $display("FAIL restart_mid_cnt got %0d want 5", bus.sample_count); else n_pass++;
    n_checks++; if (bus.signature !== exp1) $display("FAIL restart_mid_sig got %h want %h", bus.signature, exp1); else n_pass++;
    do_start(0, 16'd3, exp2);
    n_checks++; if (bus.sample_count !== 16'd0) $display("FAIL restart_cnt got %0d want 0", bus.sample_count); else n_pass++;
    n_checks++; if (bus.signature !== SEED_V) $display("FAIL restart_seed got %h want %h", bus.signature, SEED_V); else n_pass++;
    feed(0, 1, ys2, 2, early, blow, tmo);
    n_checks++; if (bus.signature !== exp2) $display("FAIL restart_sig got %h want %h", bus.signature, exp2); else n_pass++;
    n_checks++; if (bus.match !== 1'b1 || bus.done !== 1'b1) $display("FAIL restart_match got match=%b done=%b want 1 1", bus.match, bus.done); else n_pass++;
    n_checks++; if (bus.sample_count !== 16'd3) $display("FAIL restart_final_cnt got %0d want 3", bus.sample_count); else n_pass++;
    $display("restart: sig=%h", bus.signature);
  endtask

  task automatic test_reset_zero();
    yv_t ys[$];
    logic [31:0] exp;
    bit early, blow, tmo;
    for (int i = 0; i < 3; i++) ys.push_back(rand_y());
    do_start(0, 16'd10, 32'h0);
    feed(0, 1, ys, 0, early, blow, tmo);
    rst_n = 1'b0;
    drive(0, 1'b1, 16'd4, 32'h0, 1'b1, rand_y());
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1'b0, '0, '0, 1'b0, '0);
    n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.match !== 1'b0) $display("FAIL midreset_flags got busy=%b done=%b match=%b want 0 0 0", bus.busy, bus.done, bus.match); else n_pass++;
    n_checks++; if (bus.signature !== SEED_V) $display("FAIL midreset_sig got %h want %h", bus.signature, SEED_V); else n_pass++;
    n_checks++; if (bus.sample_count !== 16'd0) $display("FAIL midreset_cnt got %0d want 0", bus.sample_count); else n_pass++;
    do_start(0, 16'd0, 32'hFFFFFFFF);
    n_checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) $display("FAIL zlen_done got done=%b busy=%b want 1 0", bus.done, bus.busy); else n_pass++;
    n_checks++; if (bus.signature !== SEED_V) $display("FAIL zlen_sig got %h want %h", bus.signature, SEED_V); else n_pass++;
    n_checks++; if (bus.match !== 1'b1) $display("FAIL zlen_match got %b want 1", bus.match); else n_pass++;
    do_start(0, 16'd0, 32'h12345678);
    n_checks++; if (bus.match !== 1'b0 || bus.done !== 1'b1) $display("FAIL zlen_mismatch got match=%b done=%b want 0 1", bus.match, bus.done); else n_pass++;
    ys.delete();
    ys.push_back(rand_y());
    ys.push_back(rand_y());
    exp = model_sig(ys);
    do_start(0, 16'd2, 32'h0);
    n_checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b1) $display("FAIL done_restart got done=%b busy=%b want 0 1", bus.done, bus.busy); else n_pass++;
    feed(0, 1, ys, 1, early, blow, tmo);
    n_checks++; if (bus.signature !== exp) $display("FAIL after_done_sig got %h want %h", bus.signature, exp); else n_pass++;
    $display("reset_zero: sig=%h", bus.signature);
  endtask

  task automatic test_random();
    yv_t ys[$];
    logic [31:0] exp, gold;
    int num;
    bit early, blow, tmo;
    for (int r = 0; r < 6; r++) begin
      ys.delete();
      num = $urandom_range(1, 8);
      for (int i = 0; i < num; i++) ys.push_back(rand_y());
      exp  = model_sig(ys);
      gold = ($urandom_range(0, 1) == 1) ? exp : $urandom();
      do_start(0, 16'(num), gold);
      feed(0, 1, ys, 2, early, blow, tmo);
      n_checks++; if (tmo || early || blow) $display("FAIL rand_timing run=%0d got tmo=%b early=%b blow=%b want 0 0 0", r, tmo, early, blow); else n_pass++;
      n_checks++; if (bus.signature !== exp) $display("FAIL rand_sig run=%0d got %h want %h", r, bus.signature, exp); else n_pass++;
      n_checks++; if (bus.sample_count !== 16'(num)) $display("FAIL rand_cnt run=%0d got %0d want %0d", r, bus.sample_count, num); else n_pass++;
      n_checks++; if (bus.match !== (gold == exp) || bus.done !== 1'b1) $display("FAIL rand_match run=%0d got match=%b done=%b want %b 1", r, bus.match, bus.done, gold == exp); else n_pass++;
      $display("random run=%0d num=%0d sig=%h match=%b", r, num, bus.signature, bus.match);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 1'b0, '0, '0, 1'b0, '0);
    drive(1, 1'b0, '0, '0, 1'b0, '0);
    @(negedge clk);
    test_reset();
    test_all_zero();
    test_fold();
    test_gaps();
    test_restart();
    test_reset_zero();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
